// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back FIFO in front of the register file's
// single write port, with two-port forwarding of the newest queued value.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid/in_ready             request handshake (in_reg, in_data payload)
//   drain_en                      register-file write port granted this cycle
//   write/writeReg/writeData      head entry presented to the register file
//   fwd_reg1/2 -> fwd_hit1/2,     newest queued value for each lookup address
//                 fwd_data1/2
//   count                         occupied entries
//
// Optional feature: define REGFILE_WB_ZERO_REG_EN to discard writes to r0
// (handshake still completes) and suppress forwarding for address 0.
module regfile_wb_queue #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_reg,
  input  logic [DATAWIDTH-1:0]   in_data,
  input  logic                   drain_en,
  output logic                   write,
  output logic [4:0]             writeReg,
  output logic [DATAWIDTH-1:0]   writeData,
  input  logic [4:0]             fwd_reg1,
  input  logic [4:0]             fwd_reg2,
  output logic                   fwd_hit1,
  output logic                   fwd_hit2,
  output logic [DATAWIDTH-1:0]   fwd_data1,
  output logic [DATAWIDTH-1:0]   fwd_data2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]           reg_q  [DEPTH];
  logic [DATAWIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 look1_ok;
  logic                 look2_ok;

  // Handshake and enqueue decision; reset wins over push and pop.
  assign in_ready = (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready && !rst;
`ifdef REGFILE_WB_ZERO_REG_EN
  assign push     = accept && (in_reg != 5'd0);
  assign look1_ok = (fwd_reg1 != 5'd0);
  assign look2_ok = (fwd_reg2 != 5'd0);
`else
  assign push     = accept;
  assign look1_ok = 1'b1;
  assign look2_ok = 1'b1;
`endif

  // Head presentation to the register file.
  assign write     = (count != CW'(0)) && drain_en && !rst;
  assign pop       = write;
  assign writeReg  = (count != CW'(0)) ? reg_q[rd_ptr]  : 5'd0;
  assign writeData = (count != CW'(0)) ? data_q[rd_ptr] : '0;

  // Pointers and occupancy; pointer width makes the wrap implicit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_q[wr_ptr]  <= in_reg;
      data_q[wr_ptr] <= in_data;
    end
  end

  // Forwarding: walk occupied entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = '0;
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (look1_ok && (reg_q[idx] == fwd_reg1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_q[idx];
        end
        if (look2_ok && (reg_q[idx] == fwd_reg2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
module tb_regfile_wb_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        drain_en;
  logic        write;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [4:0]  fwd_reg1;
  logic [4:0]  fwd_reg2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  regfile_wb_queue #(.DATAWIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .write(write), .writeReg(writeReg), .writeData(writeData),
    .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        rst, v;
    logic [4:0]  rg;
    logic [31:0] d;
    logic        de;
    logic [4:0]  f1, f2;
    logic [2:0]  ec;
    logic        er, ew;
    logic [4:0]  ewr;
    logic [31:0] ewd;
    logic        eh1;
    logic [31:0] ed1;
    logic        eh2;
  } vec_t;

  ent_t q[$];
  vec_t tbl[$];
  int   tests  = 0;
  int   fails  = 0;
  int   stalls = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] rg, input logic [31:0] d,
                       input logic de, input logic [4:0] f1, input logic [4:0] f2);
    rst = r; in_valid = v; in_reg = rg; in_data = d; drain_en = de;
    fwd_reg1 = f1; fwd_reg2 = f2;
  endtask

  // Reference lookup: youngest matching queued entry.
  function automatic void mfwd(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = 32'h0;
`ifdef REGFILE_WB_ZERO_REG_EN
    if (a == 5'd0) return;
`endif
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].r == a) begin
        h = 1'b1;
        d = q[i].d;
        break;
      end
    end
  endfunction

  task automatic check_model();
    logic        h;
    logic [31:0] d;
    logic        busy;
    busy = (q.size() > 0);
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("write", 64'(write), 64'(!rst && drain_en && busy));
    chk("writeReg", 64'(writeReg), busy ? 64'(q[0].r) : 64'(0));
    chk("writeData", 64'(writeData), busy ? 64'(q[0].d) : 64'(0));
    mfwd(fwd_reg1, h, d);
    chk("fwd_hit1", 64'(fwd_hit1), 64'(h));
    chk("fwd_data1", 64'(fwd_data1), 64'(d));
    mfwd(fwd_reg2, h, d);
    chk("fwd_hit2", 64'(fwd_hit2), 64'(h));
    chk("fwd_data2", 64'(fwd_data2), 64'(d));
    if (in_valid && !in_ready) stalls++;
  endtask

  task automatic update_model();
    logic acc;
    acc = in_valid && (q.size() < DEPTH);
    if (rst) begin
      q.delete();
    end else begin
      if (drain_en && q.size() > 0) void'(q.pop_front());
`ifdef REGFILE_WB_ZERO_REG_EN
      if (acc && in_reg != 5'd0) q.push_back('{r: in_reg, d: in_data});
`else
      if (acc) q.push_back('{r: in_reg, d: in_data});
`endif
    end
  endtask

  task automatic pre();
    @(negedge clk);
    check_model();
  endtask

  task automatic post();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic add(input logic r, input logic v, input logic [4:0] rg, input logic [31:0] d,
                     input logic de, input logic [4:0] f1, input logic [4:0] f2,
                     input logic [2:0] ec, input logic er, input logic ew,
                     input logic [4:0] ewr, input logic [31:0] ewd,
                     input logic eh1, input logic [31:0] ed1, input logic eh2);
    tbl.push_back('{rst: r, v: v, rg: rg, d: d, de: de, f1: f1, f2: f2, ec: ec, er: er,
                    ew: ew, ewr: ewr, ewd: ewd, eh1: eh1, ed1: ed1, eh2: eh2});
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31);

    // Reset, fill, drain in order.
    add(1,0,5'd0,32'h00,0,5'd0,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
    add(1,0,5'd0,32'h00,0,5'd0,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
    add(0,1,5'd1,32'h11,0,5'd1,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
    add(0,1,5'd2,32'h22,0,5'd1,5'd31, 3'd1,1,0,5'd1,32'h11, 1,32'h11,0);
    add(0,1,5'd3,32'h33,0,5'd1,5'd31, 3'd2,1,0,5'd1,32'h11, 1,32'h11,0);
    add(0,1,5'd4,32'h44,0,5'd1,5'd31, 3'd3,1,0,5'd1,32'h11, 1,32'h11,0);
    add(0,0,5'd0,32'h00,0,5'd4,5'd31, 3'd4,0,0,5'd1,32'h11, 1,32'h44,0);
    add(0,0,5'd0,32'h00,1,5'd1,5'd31, 3'd4,0,1,5'd1,32'h11, 1,32'h11,0);
    add(0,0,5'd0,32'h00,1,5'd1,5'd31, 3'd3,1,1,5'd2,32'h22, 0,32'h00,0);
    add(0,0,5'd0,32'h00,1,5'd1,5'd31, 3'd2,1,1,5'd3,32'h33, 0,32'h00,0);
    add(0,0,5'd0,32'h00,1,5'd1,5'd31, 3'd1,1,1,5'd4,32'h44, 0,32'h00,0);
    add(0,0,5'd0,32'h00,1,5'd1,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
    // Forward newest of duplicate destinations.
    add(0,1,5'd5,32'h0A,0,5'd5,5'd6,  3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
    add(0,1,5'd5,32'h0B,0,5'd5,5'd6,  3'd1,1,0,5'd5,32'h0A, 1,32'h0A,0);
    add(0,0,5'd0,32'h00,0,5'd5,5'd6,  3'd2,1,0,5'd5,32'h0A, 1,32'h0B,0);
    // Reset with a request present drops both the queue and the request.
    add(1,1,5'd7,32'h77,1,5'd5,5'd31, 3'd2,1,0,5'd5,32'h0A, 1,32'h0B,0);
    add(0,0,5'd0,32'h00,1,5'd7,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
    // Register 0 destination.
    add(0,1,5'd0,32'hFF,0,5'd0,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
`ifdef REGFILE_WB_ZERO_REG_EN
    add(0,0,5'd0,32'h00,1,5'd0,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);
`else
    add(0,0,5'd0,32'h00,1,5'd0,5'd31, 3'd1,1,1,5'd0,32'hFF, 1,32'hFF,0);
`endif
    add(0,0,5'd0,32'h00,0,5'd0,5'd31, 3'd0,1,0,5'd0,32'h00, 0,32'h00,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].v, tbl[i].rg, tbl[i].d, tbl[i].de, tbl[i].f1, tbl[i].f2);
      pre();
      chk($sformatf("v%0d.count", i), 64'(count), 64'(tbl[i].ec));
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(tbl[i].er));
      chk($sformatf("v%0d.write", i), 64'(write), 64'(tbl[i].ew));
      chk($sformatf("v%0d.writeReg", i), 64'(writeReg), 64'(tbl[i].ewr));
      chk($sformatf("v%0d.writeData", i), 64'(writeData), 64'(tbl[i].ewd));
      chk($sformatf("v%0d.fwd_hit1", i), 64'(fwd_hit1), 64'(tbl[i].eh1));
      chk($sformatf("v%0d.fwd_data1", i), 64'(fwd_data1), 64'(tbl[i].ed1));
      chk($sformatf("v%0d.fwd_hit2", i), 64'(fwd_hit2), 64'(tbl[i].eh2));
      post();
    end

    // Steady push+pop at occupancy 2 across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 5'(8 + i), 32'(32'h100 + i), 1'b0, 5'd8, 5'd9);
      pre();
      post();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 5'(10 + i), 32'(32'h200 + i), 1'b1, 5'(10 + i), 5'(8 + i));
      pre();
      chk("pp.count", 64'(count), 64'd2);
      chk("pp.write", 64'(write), 64'd1);
      post();
    end
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd31);
    for (int i = 0; i < 3; i++) begin
      pre();
      post();
    end

    // Reset mid-operation with 3 entries queued and a request presented.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 5'(20 + i), 32'(32'h300 + i), 1'b0, 5'd9, 5'd20);
      pre();
      post();
    end
    drive(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 5'd20);
    pre();
    chk("rstmid.write", 64'(write), 64'd0);
    chk("rstmid.count", 64'(count), 64'd3);
    post();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd20);
    for (int i = 0; i < 3; i++) begin
      pre();
      chk("rstafter.count", 64'(count), 64'd0);
      chk("rstafter.write", 64'(write), 64'd0);
      chk("rstafter.hit", 64'(fwd_hit1), 64'd0);
      post();
    end

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) == 0), 1'($urandom), 5'($urandom_range(0, 7)),
            $urandom, ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
      pre();
      post();
    end

    $display("[TB] stall cycles observed: %0d", stalls);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
